// File: rtl/traffic_lights_xing.sv
// traffic_lights_xing: multi-direction intersection controller.
// Grants right-of-way round-robin across NUM_DIRS signal heads with an
// all-red clearance interval between grants. Programmable periods are held
// in ms; a prescaler converts clock cycles to ms for any clock rate.
module traffic_lights_xing #(
  parameter int NUM_DIRS              = 4,
  parameter int CLK_PER_MS            = 2,
  parameter int BLINK_HALF_PERIOD_MS  = 10,
  parameter int BLINK_GREEN_TIME_TICK = 2,
  parameter int RED_YELLOW_MS         = 5,
  parameter int DEFAULT_GREEN_MS      = 10,
  parameter int DEFAULT_YELLOW_MS     = 10,
  parameter int DEFAULT_CLEAR_MS      = 10,
  parameter int DIR_W                 = $clog2(NUM_DIRS)
) (
  input  logic                clk_i,
  input  logic                srst_i,
  input  logic                cmd_valid_i,
  input  logic [2:0]          cmd_type_i,
  input  logic [DIR_W-1:0]    cmd_dir_i,
  input  logic [15:0]         cmd_data_i,
  output logic [NUM_DIRS-1:0] red_o,
  output logic [NUM_DIRS-1:0] yellow_o,
  output logic [NUM_DIRS-1:0] green_o,
  output logic [DIR_W-1:0]    active_dir_o
);

  localparam int                 PRESC_W   = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_PER_MS - 1);
  localparam logic [15:0]        RY_MS     = 16'(RED_YELLOW_MS);
  localparam logic [15:0]        GT_MS     = 16'(2 * BLINK_HALF_PERIOD_MS * BLINK_GREEN_TIME_TICK);
  localparam logic [15:0]        HALF_MAX  = 16'(BLINK_HALF_PERIOD_MS - 1);
  localparam logic [DIR_W-1:0]   LAST_DIR  = DIR_W'(NUM_DIRS - 1);
  localparam logic [15:0]        DEF_GREEN  = 16'(DEFAULT_GREEN_MS);
  localparam logic [15:0]        DEF_YELLOW = 16'(DEFAULT_YELLOW_MS);
  localparam logic [15:0]        DEF_CLEAR  = 16'(DEFAULT_CLEAR_MS);

  // RUN phases first so that reset (CLEAR) is the zero encoding
  typedef enum logic [2:0] {
    S_CLEAR,
    S_RY,
    S_G,
    S_GT,
    S_Y,
    S_NOTRANS,
    S_OFF
  } state_e;

  typedef enum logic [2:0] {
    CMD_ON         = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_NOTRANS    = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_CLEAR  = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_e;

  state_e               state_q, state_d;
  logic [DIR_W-1:0]     dir_q, dir_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [15:0]          ms_q, ms_d;
  logic [15:0]          bcnt_q, bcnt_d;
  logic                 blink_q, blink_d;

  logic [15:0]          green_ms_q  [NUM_DIRS];
  logic [15:0]          yellow_ms_q [NUM_DIRS];
  logic [15:0]          clear_ms_q;

  logic [15:0]          period_raw;
  logic [15:0]          period_eff;
  logic                 in_run;
  logic                 phase_done;
  logic                 cmd_taken;
  logic                 restart;
  logic                 dir_ok;
  logic [NUM_DIRS-1:0]  dir_oh;

  assign dir_ok = (32'(cmd_dir_i) < NUM_DIRS);
  assign in_run = (state_q != S_NOTRANS) && (state_q != S_OFF);

  // Duration of the current RUN phase in ms; zero is stretched to 1 ms
  always_comb begin
    period_raw = 16'd1;
    case (state_q)
      S_CLEAR: period_raw = clear_ms_q;
      S_RY:    period_raw = RY_MS;
      S_G:     period_raw = green_ms_q[dir_q];
      S_GT:    period_raw = GT_MS;
      S_Y:     period_raw = yellow_ms_q[dir_q];
      default: period_raw = 16'd1;
    endcase
    period_eff = (period_raw == '0) ? 16'd1 : period_raw;
  end

  assign phase_done = in_run && (presc_q == PRESC_MAX) && (ms_q == (period_eff - 16'd1));

  // Next state: effective commands pre-empt a phase timeout at the same edge
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cmd_taken = 1'b0;
    restart   = 1'b0;
    presc_d   = presc_q;
    ms_d      = ms_q;
    bcnt_d    = bcnt_q;
    blink_d   = blink_q;

    if (cmd_valid_i) begin
      case (cmd_type_i)
        CMD_ON: begin
          if (!in_run) begin
            state_d   = S_CLEAR;
            dir_d     = '0;
            cmd_taken = 1'b1;
          end
        end
        CMD_OFF: begin
          state_d   = S_OFF;
          cmd_taken = 1'b1;
        end
        CMD_NOTRANS: begin
          state_d   = S_NOTRANS;
          cmd_taken = 1'b1;
        end
        default: ;
      endcase
    end

    if (cmd_taken) begin
      restart = 1'b1;
    end else if (phase_done) begin
      restart = 1'b1;
      case (state_q)
        S_CLEAR: state_d = S_RY;
        S_RY:    state_d = S_G;
        S_G:     state_d = S_GT;
        S_GT:    state_d = S_Y;
        S_Y: begin
          state_d = S_CLEAR;
          dir_d   = (dir_q == LAST_DIR) ? '0 : dir_q + DIR_W'(1);
        end
        default: ;
      endcase
    end

    // Blink is phase-relative: it restarts lit together with the timers
    if (restart) begin
      presc_d = '0;
      ms_d    = '0;
      bcnt_d  = '0;
      blink_d = 1'b1;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      ms_d    = ms_q + 16'd1;
      if (bcnt_q == HALF_MAX) begin
        bcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + 16'd1;
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // State and timer registers
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= S_CLEAR;
      dir_q   <= '0;
      presc_q <= '0;
      ms_q    <= '0;
      bcnt_q  <= '0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      ms_q    <= ms_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  // Period table; writable only while the intersection is in NOTRANSITION
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      green_ms_q  <= '{default: DEF_GREEN};
      yellow_ms_q <= '{default: DEF_YELLOW};
      clear_ms_q  <= DEF_CLEAR;
    end else if (cmd_valid_i && (state_q == S_NOTRANS)) begin
      case (cmd_type_i)
        CMD_SET_GREEN:  if (dir_ok) green_ms_q[cmd_dir_i] <= cmd_data_i;
        CMD_SET_CLEAR:  clear_ms_q <= cmd_data_i;
        CMD_SET_YELLOW: if (dir_ok) yellow_ms_q[cmd_dir_i] <= cmd_data_i;
        default: ;
      endcase
    end
  end

  assign dir_oh = {{(NUM_DIRS-1){1'b0}}, 1'b1} << dir_q;

  // Lamp decode from registered state only
  always_comb begin
    red_o    = '0;
    yellow_o = '0;
    green_o  = '0;
    case (state_q)
      S_CLEAR: red_o = '1;
      S_RY: begin
        red_o    = '1;
        yellow_o = dir_oh;
      end
      S_G: begin
        red_o   = ~dir_oh;
        green_o = dir_oh;
      end
      S_GT: begin
        red_o   = ~dir_oh;
        green_o = blink_q ? dir_oh : '0;
      end
      S_Y: begin
        red_o    = ~dir_oh;
        yellow_o = dir_oh;
      end
      S_NOTRANS: yellow_o = {NUM_DIRS{blink_q}};
      default: ;
    endcase
  end

  assign active_dir_o = dir_q;

endmodule

// File: tb/tb_traffic_lights_xing.sv
// Testbench for traffic_lights_xing (3 directions, 2 clocks per ms).
// Each driven cycle pushes the expected lamp word; a monitor pops and
// compares it shortly after the following rising edge.
module tb_traffic_lights_xing;

  localparam int ND        = 3;
  localparam int DW        = 2;
  localparam int BLINK_CYC = 20;

  logic          clk = 1'b0;
  logic          srst;
  logic          cmd_valid;
  logic [2:0]    cmd_type;
  logic [DW-1:0] cmd_dir;
  logic [15:0]   cmd_data;
  logic [ND-1:0] red, yellow, green;
  logic [DW-1:0] active_dir;

  traffic_lights_xing #(
    .NUM_DIRS   (ND),
    .CLK_PER_MS (2)
  ) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .cmd_valid_i  (cmd_valid),
    .cmd_type_i   (cmd_type),
    .cmd_dir_i    (cmd_dir),
    .cmd_data_i   (cmd_data),
    .red_o        (red),
    .yellow_o     (yellow),
    .green_o      (green),
    .active_dir_o (active_dir)
  );

  always #5 clk = ~clk;

  typedef enum int {K_CLEAR, K_RY, K_G, K_GT, K_Y, K_NT, K_OFF} kind_e;

  logic [10:0] exp_q[$];
  logic [10:0] mask_q[$];
  string       tag_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @%0t: got r/y/g/dir=%b expected %b", tag, $time, got, exp);
  endtask

  function automatic bit lit_at(input int i);
    return ((i / BLINK_CYC) % 2) == 0;
  endfunction

  // Expected {red, yellow, green, active_dir} for one cycle
  function automatic logic [10:0] exp_word(input kind_e k, input int d, input bit lit);
    logic [2:0] one, oh, r, y, g;
    one = 3'b001;
    oh  = one << d;
    r = '0; y = '0; g = '0;
    case (k)
      K_CLEAR: r = 3'b111;
      K_RY:    begin r = 3'b111; y = oh; end
      K_G:     begin r = ~oh; g = oh; end
      K_GT:    begin r = ~oh; g = lit ? oh : 3'b000; end
      K_Y:     begin r = ~oh; y = oh; end
      K_NT:    y = lit ? 3'b111 : 3'b000;
      default: ;
    endcase
    return {r, y, g, 2'(d)};
  endfunction

  task automatic drv(input bit rst, input bit v, input logic [2:0] t, input int d,
                     input logic [15:0] data, input kind_e k, input int ed,
                     input bit lit, input string tag);
    srst      = rst;
    cmd_valid = v;
    cmd_type  = t;
    cmd_dir   = 2'(d);
    cmd_data  = data;
    exp_q.push_back(exp_word(k, ed, lit));
    mask_q.push_back((k == K_NT || k == K_OFF) ? 11'h7FC : 11'h7FF);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic idle(input kind_e k, input int d, input int n, input string tag);
    for (int i = 0; i < n; i++) drv(1'b0, 1'b0, 3'd0, 0, 16'd0, k, d, 1'b1, tag);
  endtask

  task automatic blink(input kind_e k, input int d, input int first, input int n, input string tag);
    for (int i = first; i < first + n; i++) drv(1'b0, 1'b0, 3'd0, 0, 16'd0, k, d, lit_at(i), tag);
  endtask

  logic [10:0] mon_e, mon_m;
  string       mon_t;

  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_m = mask_q.pop_front();
      mon_t = tag_q.pop_front();
      check_eq(mon_t, {red, yellow, green, active_dir} & mon_m, mon_e & mon_m);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    srst = 1'b1; cmd_valid = 1'b0; cmd_type = '0; cmd_dir = '0; cmd_data = '0;
    @(negedge clk);

    // Reset and a full free-running round over all directions
    for (int i = 0; i < 3; i++) drv(1'b1, 1'b0, 3'd0, 0, 16'd0, K_CLEAR, 0, 1'b1, "reset");
    idle(K_CLEAR, 0, 19, "clear_d0");
    for (int d = 0; d < ND; d++) begin
      idle(K_RY, d, 10, "ry");
      idle(K_G, d, 20, "g");
      blink(K_GT, d, 0, 80, "gt");
      idle(K_Y, d, 20, "y");
      idle(K_CLEAR, (d + 1) % ND, 20, "clear_next");
    end
    idle(K_RY, 0, 10, "wrap_ry0");

    // NOTRANSITION at the RY->G boundary, then programming
    drv(1'b0, 1'b1, 3'd2, 0, 16'd0, K_NT, 0, lit_at(0), "nt_over_timeout");
    drv(1'b0, 1'b1, 3'd3, 1, 16'd3, K_NT, 0, lit_at(1), "wr_green1");
    drv(1'b0, 1'b1, 3'd5, 3, 16'd1, K_NT, 0, lit_at(2), "wr_bad_dir");
    drv(1'b0, 1'b1, 3'd4, 0, 16'd0, K_NT, 0, lit_at(3), "wr_clear0");
    blink(K_NT, 0, 4, 36, "nt_blink");

    // Run with programmed periods; a write during RUN is ignored
    drv(1'b0, 1'b1, 3'd0, 0, 16'd0, K_CLEAR, 0, 1'b1, "on");
    idle(K_CLEAR, 0, 1, "clear_zero_2cyc");
    idle(K_RY, 0, 10, "ry0");
    idle(K_G, 0, 10, "g0_default");
    drv(1'b0, 1'b1, 3'd5, 1, 16'd7, K_G, 0, 1'b1, "run_wr_ignored");
    idle(K_G, 0, 9, "g0_default");
    blink(K_GT, 0, 0, 80, "gt0");
    idle(K_Y, 0, 20, "y0");
    idle(K_CLEAR, 1, 2, "clear1_short");
    idle(K_RY, 1, 10, "ry1");
    idle(K_G, 1, 6, "g1_prog");
    blink(K_GT, 1, 0, 80, "gt1");
    idle(K_Y, 1, 20, "y1_default");
    idle(K_CLEAR, 2, 2, "clear2_short");
    idle(K_RY, 2, 10, "ry2");
    idle(K_G, 2, 5, "g2");

    // OFF during dir2 green; writes in OFF are ignored
    drv(1'b0, 1'b1, 3'd1, 0, 16'd0, K_OFF, 0, 1'b1, "off");
    drv(1'b0, 1'b1, 3'd3, 0, 16'd2, K_OFF, 0, 1'b1, "off_wr_ignored");
    idle(K_OFF, 0, 3, "off_hold");
    drv(1'b0, 1'b1, 3'd0, 0, 16'd0, K_CLEAR, 0, 1'b1, "on_from_off");
    idle(K_CLEAR, 0, 1, "clear0_short");
    idle(K_RY, 0, 10, "ry0");
    idle(K_G, 0, 20, "g0_unchanged");
    blink(K_GT, 0, 0, 80, "gt0");
    idle(K_Y, 0, 20, "y0_full");

    // NOTRANSITION in the last Y cycle wins; re-issue restarts blink lit
    drv(1'b0, 1'b1, 3'd2, 0, 16'd0, K_NT, 0, lit_at(0), "nt_over_y_end");
    blink(K_NT, 0, 1, 24, "nt_blink2");
    drv(1'b0, 1'b1, 3'd2, 0, 16'd0, K_NT, 0, lit_at(0), "nt_restart");
    blink(K_NT, 0, 1, 22, "nt_blink3");

    // Reset mid-GT with a simultaneous OFF command
    drv(1'b0, 1'b1, 3'd0, 0, 16'd0, K_CLEAR, 0, 1'b1, "on2");
    idle(K_CLEAR, 0, 1, "clear0_short");
    idle(K_RY, 0, 10, "ry0");
    idle(K_G, 0, 20, "g0");
    blink(K_GT, 0, 0, 30, "gt0_part");
    drv(1'b1, 1'b1, 3'd1, 0, 16'd0, K_CLEAR, 0, 1'b1, "rst_over_cmd");
    idle(K_CLEAR, 0, 19, "clear_default");
    idle(K_RY, 0, 10, "ry0_after_rst");
    idle(K_G, 0, 20, "g0_after_rst");
    blink(K_GT, 0, 0, 5, "gt0_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
